// File: rtl/aclk_key_entry.sv
// Keypad front end of the alarm clock.
// Collects four HH:MM digits from key strobes, selects what the LCD shows and
// issues one-cycle load commands for the alarm register and the time counter.
// Ports:
//   clock, reset (sync, active-low)       - clocking and reset
//   one_second                            - 1 Hz tick from timegen, drives the idle timeout
//   key_valid, key[3:0]                   - key strobe and code (0-9, A=ALARM, B=TIME, C=CLEAR)
//   key_ms_hr..key_ls_min[3:0]            - entered HH:MM digits
//   show_new_time, show_a                 - LCD source selects
//   load_new_a, load_new_c, entry_error   - one-cycle command/error pulses
module aclk_key_entry #(
    parameter int unsigned TIMEOUT_SEC = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       one_second,
    input  logic       key_valid,
    input  logic [3:0] key,
    output logic [3:0] key_ms_hr,
    output logic [3:0] key_ls_hr,
    output logic [3:0] key_ms_min,
    output logic [3:0] key_ls_min,
    output logic       show_new_time,
    output logic       show_a,
    output logic       load_new_a,
    output logic       load_new_c,
    output logic       entry_error
);

    localparam int unsigned DW = 4;
    localparam int unsigned CW = 3;
    localparam int unsigned TW = 4;

    typedef enum logic [1:0] {
        S_TIME  = 2'd0,
        S_ENTRY = 2'd1,
        S_ALARM = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   count;
    logic [TW-1:0]   tmo;

    logic [DW-1:0]   ms_hr_nxt, ls_hr_nxt, ms_min_nxt, ls_min_nxt;
    logic [CW-1:0]   count_nxt;
    logic [TW-1:0]   tmo_nxt;
    logic            load_a_nxt, load_c_nxt, err_nxt;

    // Key decode; codes D-F are not accepted at all
    logic key_acc, key_digit, key_alarm, key_time, key_clear;
    logic full, time_ok, tmo_hit;
    logic [TW-1:0] tmo_inc;

    always_comb begin
        key_acc   = key_valid && (key <= DW'(4'hC));
        key_digit = key_valid && (key <= DW'(4'd9));
        key_alarm = key_valid && (key == DW'(4'hA));
        key_time  = key_valid && (key == DW'(4'hB));
        key_clear = key_valid && (key == DW'(4'hC));
        full      = (count == CW'(3'd4));
        time_ok   = ((key_ms_hr < DW'(4'd2)) ||
                     ((key_ms_hr == DW'(4'd2)) && (key_ls_hr <= DW'(4'd3)))) &&
                    (key_ms_min <= DW'(4'd5));
        tmo_inc   = tmo + TW'(1);
        // An accepted key in the same cycle suppresses the timeout
        tmo_hit   = one_second && !key_acc && (state != S_TIME) &&
                    (tmo_inc == TW'(TIMEOUT_SEC));
    end

    // State register
    always_ff @(posedge clock) begin
        if (!reset) state <= S_TIME;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_TIME: begin
                if (key_digit)      state_nxt = S_ENTRY;
                else if (key_alarm) state_nxt = S_ALARM;
            end
            S_ENTRY: begin
                if (key_alarm || key_time || key_clear) state_nxt = S_TIME;
                else if (tmo_hit)                       state_nxt = S_TIME;
            end
            S_ALARM: begin
                if (key_acc || tmo_hit) state_nxt = S_TIME;
            end
            default: state_nxt = S_TIME;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        ms_hr_nxt  = key_ms_hr;
        ls_hr_nxt  = key_ls_hr;
        ms_min_nxt = key_ms_min;
        ls_min_nxt = key_ls_min;
        count_nxt  = count;
        load_a_nxt = 1'b0;
        load_c_nxt = 1'b0;
        err_nxt    = 1'b0;

        if ((state_nxt == S_TIME) || key_acc || tmo_hit) tmo_nxt = '0;
        else if (one_second)                             tmo_nxt = tmo_inc;
        else                                             tmo_nxt = tmo;

        case (state)
            S_TIME: begin
                // First digit starts a fresh entry: 0,0,0,d
                if (key_digit) begin
                    ms_hr_nxt  = '0;
                    ls_hr_nxt  = '0;
                    ms_min_nxt = '0;
                    ls_min_nxt = key;
                    count_nxt  = CW'(3'd1);
                end
            end
            S_ENTRY: begin
                if (key_digit && !full) begin
                    ms_hr_nxt  = key_ls_hr;
                    ls_hr_nxt  = key_ms_min;
                    ms_min_nxt = key_ls_min;
                    ls_min_nxt = key;
                    count_nxt  = count + CW'(1);
                end else if (key_alarm || key_time) begin
                    if (full && time_ok) begin
                        load_a_nxt = key_alarm;
                        load_c_nxt = key_time;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end else if (key_clear) begin
                    ms_hr_nxt  = '0;
                    ls_hr_nxt  = '0;
                    ms_min_nxt = '0;
                    ls_min_nxt = '0;
                    count_nxt  = '0;
                end
            end
            default: ;
        endcase
    end

    // Registered outputs and datapath
    always_ff @(posedge clock) begin
        if (!reset) begin
            key_ms_hr     <= '0;
            key_ls_hr     <= '0;
            key_ms_min    <= '0;
            key_ls_min    <= '0;
            count         <= '0;
            tmo           <= '0;
            show_new_time <= 1'b0;
            show_a        <= 1'b0;
            load_new_a    <= 1'b0;
            load_new_c    <= 1'b0;
            entry_error   <= 1'b0;
        end else begin
            key_ms_hr     <= ms_hr_nxt;
            key_ls_hr     <= ls_hr_nxt;
            key_ms_min    <= ms_min_nxt;
            key_ls_min    <= ls_min_nxt;
            count         <= count_nxt;
            tmo           <= tmo_nxt;
            // Registered decode of the next state tracks the state register exactly
            show_new_time <= (state_nxt == S_ENTRY);
            show_a        <= (state_nxt == S_ALARM);
            load_new_a    <= load_a_nxt;
            load_new_c    <= load_c_nxt;
            entry_error   <= err_nxt;
        end
    end

endmodule

// File: tb/tb_aclk_key_entry.sv
// Self-checking bench for aclk_key_entry: directed test-plan steps followed by
// random key/tick traffic, compared every cycle against a queue-based model.
module tb_aclk_key_entry;

    localparam int TO = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       one_second = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key = 4'd0;
    logic [3:0] key_ms_hr, key_ls_hr, key_ms_min, key_ls_min;
    logic       show_new_time, show_a, load_new_a, load_new_c, entry_error;

    int checks = 0;
    int errors = 0;

    aclk_key_entry #(.TIMEOUT_SEC(TO)) dut (
        .clock        (clock),
        .reset        (reset),
        .one_second   (one_second),
        .key_valid    (key_valid),
        .key          (key),
        .key_ms_hr    (key_ms_hr),
        .key_ls_hr    (key_ls_hr),
        .key_ms_min   (key_ms_min),
        .key_ls_min   (key_ls_min),
        .show_new_time(show_new_time),
        .show_a       (show_a),
        .load_new_a   (load_new_a),
        .load_new_c   (load_new_c),
        .entry_error  (entry_error)
    );

    always #5 clock = ~clock;

    // Reference model: mode name, the entered digits as a queue (display shows
    // the last four, zero padded on the left), and seconds spent idle.
    typedef enum int {M_TIME, M_ENTRY, M_ALARM} mode_t;
    mode_t mode = M_TIME;
    int    q[$];
    int    idle = 0;
    bit    m_load_a, m_load_c, m_err;

    function automatic int shown(input int pos);
        int idx;
        idx = pos - (4 - q.size());
        return (idx < 0) ? 0 : q[idx];
    endfunction

    function automatic bit entered_time_ok();
        int hh, mm;
        hh = shown(0) * 10 + shown(1);
        mm = shown(2) * 10 + shown(3);
        return (hh <= 23) && (mm <= 59);
    endfunction

    task automatic tick();
        idle++;
        if (idle == TO) mode = M_TIME;
    endtask

    task automatic model_step(input bit rst_n, input bit kv, input int k, input bit os);
        bit acc;
        m_load_a = 0; m_load_c = 0; m_err = 0;
        if (!rst_n) begin
            mode = M_TIME; q.delete(); idle = 0;
            return;
        end
        acc = kv && (k <= 12);
        if (acc) idle = 0;
        case (mode)
            M_TIME: if (acc) begin
                if (k <= 9) begin q.delete(); q.push_back(k); mode = M_ENTRY; end
                else if (k == 10) mode = M_ALARM;
            end
            M_ENTRY: if (acc) begin
                if (k <= 9) begin
                    if (q.size() < 4) q.push_back(k);
                end else if (k == 12) begin
                    q.delete(); mode = M_TIME;
                end else begin
                    if (q.size() == 4 && entered_time_ok()) begin
                        if (k == 10) m_load_a = 1; else m_load_c = 1;
                    end else m_err = 1;
                    mode = M_TIME;
                end
            end else if (os) tick();
            M_ALARM: if (acc) mode = M_TIME; else if (os) tick();
            default: mode = M_TIME;
        endcase
        if (mode == M_TIME) idle = 0;
    endtask

    task automatic cmp(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        cmp("show_new_time", int'(show_new_time), int'(mode == M_ENTRY));
        cmp("show_a",        int'(show_a),        int'(mode == M_ALARM));
        cmp("key_ms_hr",     int'(key_ms_hr),     shown(0));
        cmp("key_ls_hr",     int'(key_ls_hr),     shown(1));
        cmp("key_ms_min",    int'(key_ms_min),    shown(2));
        cmp("key_ls_min",    int'(key_ls_min),    shown(3));
        cmp("load_new_a",    int'(load_new_a),    int'(m_load_a));
        cmp("load_new_c",    int'(load_new_c),    int'(m_load_c));
        cmp("entry_error",   int'(entry_error),   int'(m_err));
    endtask

    // One clock: drive, clock, update model, sample 1 time unit after the edge
    task automatic step(input bit rst_n, input bit kv, input int k, input bit os);
        reset      = rst_n;
        key_valid  = kv;
        key        = 4'(k);
        one_second = os;
        @(posedge clock);
        model_step(rst_n, kv, k, os);
        #1;
        check_all();
    endtask

    task automatic press(input int k);
        step(1, 1, k, 0);
    endtask

    task automatic idle_cycle();
        step(1, 0, 0, 0);
    endtask

    task automatic expect_digits(input int a, input int b, input int c, input int d);
        cmp("dir_ms_hr",  int'(key_ms_hr),  a);
        cmp("dir_ls_hr",  int'(key_ls_hr),  b);
        cmp("dir_ms_min", int'(key_ms_min), c);
        cmp("dir_ls_min", int'(key_ls_min), d);
    endtask

    initial begin
        // Reset
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        expect_digits(0, 0, 0, 0);

        // 1: valid alarm load
        press(1);
        cmp("dir_entry_after_first", int'(show_new_time), 1);
        press(2); press(3); press(0);
        expect_digits(1, 2, 3, 0);
        press(10);
        cmp("dir_load_a", int'(load_new_a), 1);
        cmp("dir_no_load_c", int'(load_new_c), 0);
        idle_cycle();
        cmp("dir_load_a_one_cycle", int'(load_new_a), 0);
        expect_digits(1, 2, 3, 0);

        // 2: invalid hour
        press(2); press(4); press(0); press(0); press(11);
        cmp("dir_err_hour", int'(entry_error), 1);
        cmp("dir_no_load_c_bad", int'(load_new_c), 0);
        idle_cycle();

        // 3: short entry, then overlong entry with saturation
        press(0); press(7); press(11);
        cmp("dir_err_short", int'(entry_error), 1);
        press(0); press(7); press(4); press(5); press(9);
        expect_digits(0, 7, 4, 5);
        press(11);
        cmp("dir_load_c", int'(load_new_c), 1);
        idle_cycle();

        // 4: timeout, then key coinciding with the final tick
        press(5);
        step(1, 0, 0, 1); idle_cycle(); step(1, 0, 0, 1); step(1, 0, 0, 1);
        cmp("dir_timeout", int'(show_new_time), 0);
        cmp("dir_timeout_noerr", int'(entry_error), 0);
        press(5);
        step(1, 0, 0, 1); step(1, 0, 0, 1); step(1, 1, 6, 1);
        cmp("dir_key_beats_timeout", int'(show_new_time), 1);
        press(12);

        // 5: alarm display
        press(10);
        cmp("dir_show_a", int'(show_a), 1);
        press(4);
        cmp("dir_show_a_off", int'(show_a), 0);
        cmp("dir_no_entry", int'(show_new_time), 0);
        press(10);
        for (int i = 0; i < TO; i++) step(1, 0, 0, 1);
        cmp("dir_alarm_timeout", int'(show_a), 0);

        // 6: reset mid-entry
        press(1); press(2);
        step(0, 0, 0, 0);
        expect_digits(0, 0, 0, 0);
        press(9);
        expect_digits(0, 0, 0, 9);
        press(1); press(2); press(3); press(10);  // count reached 4 after 9,1,2,3
        idle_cycle();

        // Random traffic, with key codes biased toward plausible times
        for (int n = 0; n < 4000; n++) begin
            bit rn, kv, os;
            int k;
            rn = ($urandom_range(0, 299) != 0);
            kv = ($urandom_range(0, 2) == 0);
            os = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) k = $urandom_range(0, 15);
            else if ($urandom_range(0, 4) == 0) k = $urandom_range(10, 11);
            else k = $urandom_range(0, 5);
            step(rn, kv, k, os);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aclk_key_entry.md
Name: aclk_key_entry

Overview:
Keypad front end of the alarm clock.
- Accepts one key code per `key_valid` strobe.
- Assembles the four HH:MM digits in a shift register and decides what the LCD shows.
- Issues one-cycle commands that load the entered time into the alarm register or the current-time counter.
- Its digit outputs and display selects feed the LCD display block's `key_*`, `show_a` and `show_current_time` inputs.

Parameters:
- TIMEOUT_SEC, 10: number of `one_second` pulses with no accepted key after which ENTRY or SHOW_ALARM returns to SHOW_TIME. Legal range 1..15.

Ports:
- clock, input, 1: system clock; all logic on the rising edge.
- reset, input, 1: synchronous, active-low reset.
- one_second, input, 1: one-cycle pulse once per second from the timegen block.
- key_valid, input, 1: one-cycle strobe; `key` is valid in that cycle.
- key, input, 4: key code. 0-9 = digit, 4'hA = ALARM, 4'hB = TIME, 4'hC = CLEAR. 4'hD-4'hF are ignored (no state change, timer not restarted).
- key_ms_hr, output, 4: entered hour tens digit.
- key_ls_hr, output, 4: entered hour units digit.
- key_ms_min, output, 4: entered minute tens digit.
- key_ls_min, output, 4: entered minute units digit.
- show_new_time, output, 1: display shows the entered key digits.
- show_a, output, 1: display shows the alarm time.
- load_new_a, output, 1: one-cycle pulse; the alarm register captures the `key_*` digits.
- load_new_c, output, 1: one-cycle pulse; the current-time counter captures the `key_*` digits.
- entry_error, output, 1: one-cycle pulse; a load was rejected.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state = SHOW_TIME; all `key_*` = 0; digit count = 0; timeout counter = 0.
  - All outputs = 0.
  - Reset takes priority over every event, including an entry in progress.
- States: SHOW_TIME, ENTRY, SHOW_ALARM. Moore decode from the state register:
  - show_new_time = 1 only in ENTRY.
  - show_a = 1 only in SHOW_ALARM.
  - In SHOW_TIME both are 0, so the display shows the current time.
- Accepted key = key_valid==1 with a code 0-4'hC. Each accepted key clears the timeout counter.
- Digit shift:
  - key_ms_hr <= key_ls_hr; key_ls_hr <= key_ms_min; key_ms_min <= key_ls_min; key_ls_min <= digit.
  - Digit count increments, saturating at 4.
- SHOW_TIME:
  - Digit: clear all four `key_*` digits, then load the digit into key_ls_min in the same cycle (digits read 0,0,0,d). Count = 1; go to ENTRY.
  - ALARM: go to SHOW_ALARM.
  - TIME, CLEAR: ignored.
- ENTRY:
  - Digit with count < 4: shift.
  - Digit with count == 4: the key is accepted (timer restarts), but the digits are unchanged.
  - ALARM or TIME with count == 4 and a valid time: pulse load_new_a (ALARM) or load_new_c (TIME) in the next cycle; go to SHOW_TIME.
  - Valid time means ms_hr <= 2; if ms_hr == 2 then ls_hr <= 3; ms_min <= 5. Minute units 0-9 are always valid.
  - ALARM or TIME with count < 4 or an invalid time: pulse entry_error in the next cycle; no load; go to SHOW_TIME.
  - CLEAR: all `key_*` = 0; count = 0; go to SHOW_TIME.
  - Timeout reached: go to SHOW_TIME; no load, no error; digits hold their values.
- SHOW_ALARM:
  - Any accepted key returns to SHOW_TIME, and the key is consumed (a digit does not start an entry).
  - Timeout also returns to SHOW_TIME.
- Timeout counter:
  - 4 bits. Increments on one_second in ENTRY or SHOW_ALARM; held at 0 in SHOW_TIME.
  - When it reaches TIMEOUT_SEC, the state changes in that same edge and the counter clears.
- Simultaneous events:
  - key_valid and one_second in the same cycle: the key wins; the counter clears and does not increment.
  - A timeout edge coinciding with a key: the key is processed and there is no timeout.
- Output timing:
  - load_new_a, load_new_c and entry_error are registered, high exactly one cycle, mutually exclusive.
  - `key_*` are stable during the load pulse cycle and remain at the entered value afterwards.
- No back-to-back key restriction: a strobe in consecutive cycles is processed every cycle.

Test Plan:
1. Reset, then keys 1,2,3,0,ALARM → show_new_time high after the first key; key_* = 1,2,3,0; load_new_a one cycle after the ALARM strobe; state back to SHOW_TIME; load_new_c never asserted.
2. Keys 2,4,0,0,TIME → invalid hour, entry_error pulses once; no load_new_c; show_new_time = 0.
3. Keys 0,7,TIME (count 2) → entry_error pulse; keys 0,7,4,5,9,TIME → 9 ignored, key_* = 0,7,4,5, load_new_c pulse.
4. TIMEOUT_SEC=3: key 5, then 3 one_second pulses → return to SHOW_TIME on the 3rd pulse edge, no load, no error. Repeat with a key coinciding with the 3rd pulse → stays in ENTRY.
5. ALARM from SHOW_TIME → show_a = 1; key 4 → show_a = 0 and show_new_time stays 0; ALARM again, then no keys for TIMEOUT_SEC pulses → show_a drops.
6. Keys 1,2 then reset low for one cycle → all outputs and key_* = 0; the next key 9 gives key_* = 0,0,0,9 with count 1.
